// File: rtl/sys1_input_pkg.sv
// Shared constants for the System 1 input front end: PS/2 scancodes,
// joystick/INP bit positions and the coin shaper state encoding.
package sys1_input_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_TRIG1  = 4;
  localparam int JOY_TRIG2  = 5;
  localparam int JOY_START1 = 6;
  localparam int JOY_START2 = 7;
  localparam int JOY_COIN   = 8;

  localparam int INP_LEFT   = 7;
  localparam int INP_RIGHT  = 6;
  localparam int INP_TRIG2  = 2;
  localparam int INP_TRIG1  = 1;
  localparam int INP_START2 = 5;
  localparam int INP_START1 = 4;
  localparam int INP_COIN   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_e;

  typedef struct packed {
    logic p1_up;
    logic p1_down;
    logic p1_left;
    logic p1_right;
    logic p1_trig1;
    logic p1_trig2;
    logic p2_up;
    logic p2_down;
    logic p2_left;
    logic p2_right;
    logic p2_trig1;
    logic p2_trig2;
    logic f1;
    logic f2;
    logic k1;
    logic k2;
    logic k5;
    logic k6;
  } keys_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/sys1_coin_shaper.sv
// Turns a coin request level into one fixed-width pulse followed by a lockout;
// only a fresh rising edge seen in IDLE starts a pulse.
module sys1_coin_shaper
  import sys1_input_pkg::*;
#(
  parameter int COIN_CYC = 4_800_000,
  parameter int GAP_CYC  = 4_800_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin,
  output logic busy
);

  localparam int CW = cnt_width(COIN_CYC, GAP_CYC);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(COIN_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYC - 1);

  coin_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req_prev;
  logic          r_coin;
  logic          r_busy;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req_prev <= 1'b0;
      r_coin     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Edge history runs in every state so a held request cannot re-fire after GAP.
      r_req_prev <= req;
      case (r_state)
        IDLE: begin
          if (req && !r_req_prev) begin
            r_state <= PULSE;
            r_cnt   <= PULSE_LOAD;
            r_coin  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        PULSE: begin
          if (r_cnt == '0) begin
            r_state <= GAP;
            r_cnt   <= GAP_LOAD;
            r_coin  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_coin  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign coin = r_coin;
  assign busy = r_busy;

endmodule

// File: rtl/sys1_input_ctrl.sv
// PS/2 key decode plus joystick merge producing the active-low System 1
// input ports, with the coin line conditioned by sys1_coin_shaper.
module sys1_input_ctrl
  import sys1_input_pkg::*;
#(
  parameter int CLK_HZ      = 48_000_000,
  parameter int COIN_MS     = 100,
  parameter int COIN_GAP_MS = 100
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystk1,
  input  logic [15:0] joystk2,
  input  logic        cabinet,
  output logic [7:0]  INP0,
  output logic [7:0]  INP1,
  output logic [7:0]  INP2,
  output logic        coin_busy
);

  localparam int COIN_CYC = CLK_HZ / 1000 * COIN_MS;
  localparam int GAP_CYC  = CLK_HZ / 1000 * COIN_GAP_MS;

  logic       r_primed;
  logic       r_prev_tog;
  keys_t      r_keys;
  logic [7:0] r_inp0;
  logic [7:0] r_inp1;
  logic [7:0] r_inp2;

  logic [7:0] w_code;
  logic       w_ext;
  logic       w_pressed;
  logic       w_event;
  logic       w_p1_left, w_p1_right, w_p1_trig1, w_p1_trig2;
  logic       w_p2_left, w_p2_right, w_p2_trig1, w_p2_trig2;
  logic       w_start1, w_start2, w_coin_req;
  logic       w_coin, w_busy;
  logic [7:0] w_inp0, w_inp1, w_inp2;
  logic       w_unused_bits;

  assign w_code    = ps2_key[7:0];
  assign w_ext     = ps2_key[8];
  assign w_pressed = ps2_key[9];
  assign w_event   = r_primed && (ps2_key[10] != r_prev_tog);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_primed   <= 1'b0;
      r_prev_tog <= 1'b0;
      r_keys     <= '0;
    end else begin
      r_primed   <= 1'b1;
      r_prev_tog <= ps2_key[10];
      if (w_event) begin
        // Arrows arrive both with and without the E0 prefix depending on keyboard.
        case (w_code)
          SC_UP:    r_keys.p1_up    <= w_pressed;
          SC_DOWN:  r_keys.p1_down  <= w_pressed;
          SC_LEFT:  r_keys.p1_left  <= w_pressed;
          SC_RIGHT: r_keys.p1_right <= w_pressed;
          default: begin
            if (!w_ext) begin
              case (w_code)
                SC_SPACE: r_keys.p1_trig1 <= w_pressed;
                SC_CTRL:  r_keys.p1_trig2 <= w_pressed;
                SC_F1:    r_keys.f1       <= w_pressed;
                SC_F2:    r_keys.f2       <= w_pressed;
                SC_1:     r_keys.k1       <= w_pressed;
                SC_2:     r_keys.k2       <= w_pressed;
                SC_5:     r_keys.k5       <= w_pressed;
                SC_6:     r_keys.k6       <= w_pressed;
                SC_R:     r_keys.p2_up    <= w_pressed;
                SC_F:     r_keys.p2_down  <= w_pressed;
                SC_D:     r_keys.p2_left  <= w_pressed;
                SC_G:     r_keys.p2_right <= w_pressed;
                SC_A:     r_keys.p2_trig1 <= w_pressed;
                SC_S:     r_keys.p2_trig2 <= w_pressed;
                default:  ;
              endcase
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    w_p2_left  = r_keys.p2_left  | joystk2[JOY_LEFT];
    w_p2_right = r_keys.p2_right | joystk2[JOY_RIGHT];
    w_p2_trig1 = r_keys.p2_trig1 | joystk2[JOY_TRIG1];
    w_p2_trig2 = r_keys.p2_trig2 | joystk2[JOY_TRIG2];
    // Upright cabinets share one control panel, so P2 also steers P1.
    w_p1_left  = r_keys.p1_left  | joystk1[JOY_LEFT]  | (~cabinet & w_p2_left);
    w_p1_right = r_keys.p1_right | joystk1[JOY_RIGHT] | (~cabinet & w_p2_right);
    w_p1_trig1 = r_keys.p1_trig1 | joystk1[JOY_TRIG1] | (~cabinet & w_p2_trig1);
    w_p1_trig2 = r_keys.p1_trig2 | joystk1[JOY_TRIG2] | (~cabinet & w_p2_trig2);
    w_start1   = r_keys.f1 | r_keys.k1 | joystk1[JOY_START1] | joystk2[JOY_START1];
    w_start2   = r_keys.f2 | r_keys.k2 | joystk1[JOY_START2] | joystk2[JOY_START2];
    w_coin_req = r_keys.f1 | r_keys.f2 | r_keys.k5 | r_keys.k6
               | joystk1[JOY_COIN] | joystk2[JOY_COIN];

    w_inp0 = '0;
    w_inp0[INP_LEFT]  = w_p1_left;
    w_inp0[INP_RIGHT] = w_p1_right;
    w_inp0[INP_TRIG2] = w_p1_trig2;
    w_inp0[INP_TRIG1] = w_p1_trig1;

    w_inp1 = '0;
    w_inp1[INP_LEFT]  = w_p2_left;
    w_inp1[INP_RIGHT] = w_p2_right;
    w_inp1[INP_TRIG2] = w_p2_trig2;
    w_inp1[INP_TRIG1] = w_p2_trig1;

    w_inp2 = '0;
    w_inp2[INP_START2] = w_start2;
    w_inp2[INP_START1] = w_start1;
    w_inp2[INP_COIN]   = w_coin;
  end

  sys1_coin_shaper #(
    .COIN_CYC (COIN_CYC),
    .GAP_CYC  (GAP_CYC)
  ) u_coin_shaper (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (w_coin_req),
    .coin    (w_coin),
    .busy    (w_busy)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_inp0 <= 8'hFF;
      r_inp1 <= 8'hFF;
      r_inp2 <= 8'hFF;
    end else begin
      r_inp0 <= ~w_inp0;
      r_inp1 <= ~w_inp1;
      r_inp2 <= ~w_inp2;
    end
  end

  assign INP0      = r_inp0;
  assign INP1      = r_inp1;
  assign INP2      = r_inp2;
  assign coin_busy = w_busy;

  // Up/down are decoded for completeness but have no INP bit on this board.
  assign w_unused_bits = ^{joystk1[15:9], joystk1[3:2], joystk2[15:9], joystk2[3:2],
                           r_keys.p1_up, r_keys.p1_down, r_keys.p2_up, r_keys.p2_down};

endmodule
